hex_string_sender: RTL and testbench



---
 rtl/hex_sender_pkg.sv | 20 ++
 rtl/hex_string_sender_hex_to_ascii.sv | 21 ++
 rtl/hex_string_sender.sv | 117 +++++++++++
 tb/tb_hex_string_sender.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_sender_pkg.sv
// Shared types and constants for the hex string sender.
// State encoding for the byte sequencer plus the ASCII codes it emits.
// Imported by the sequencer top and by the nibble converter.
package hex_sender_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    CR     = 2'd2,
    LF     = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // '0' for nibbles 0..9; 'A' - 10 so nibble 10..15 lands on 'A'..'F'
  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h37;

endpackage

// File: rtl/hex_string_sender_hex_to_ascii.sv
// Converts one 4-bit nibble to its uppercase ASCII hex character.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module hex_to_ascii
  import hex_sender_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Decimal digits map from '0', letters map from 'A'
  always_comb begin
    ascii = ASCII_ZERO;
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else begin
      ascii = ASCII_ALPHA_BASE + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/hex_string_sender.sv
// Prints a multi-digit hex value as ASCII bytes, MSB nibble first, optional CR LF.
// Latency: first byte valid one cycle after an accepted start; one byte per transfer.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; start ignored while busy.
module hex_string_sender
  import hex_sender_pkg::*;
#(
  parameter int unsigned NDIGITS   = 8,
  parameter bit          SEND_CRLF = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   value,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready
);

  localparam int unsigned W  = 4 * NDIGITS;
  localparam int unsigned CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

  state_t          state;
  logic [W-1:0]    shreg;
  logic [W-1:0]    shreg_next;
  logic [CW-1:0]   cnt;
  logic [3:0]      nibble;
  logic [7:0]      ascii;
  logic            xfer;

  // A byte only moves when both sides agree on the same edge
  assign xfer = tx_valid && tx_ready;

  // Shift register as it will look after the current digit is consumed
  assign shreg_next = shreg << 4;

  // In IDLE the first digit comes straight from the input value so it can be
  // registered on the start edge; afterwards it is the next digit in line
  always_comb begin
    nibble = shreg_next[W-1 -: 4];
    if (state == IDLE) begin
      nibble = value[W-1 -: 4];
    end
  end

  hex_to_ascii u_hex_to_ascii (
    .nibble (nibble),
    .ascii  (ascii)
  );

  // Byte sequencer: IDLE -> DIGITS -> (CR -> LF) -> IDLE, all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg    <= value;
            cnt      <= '0;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= ascii;
            state    <= DIGITS;
          end
        end
        DIGITS: begin
          if (xfer) begin
            if (cnt == LAST_CNT) begin
              cnt <= '0;
              if (SEND_CRLF) begin
                tx_data <= ASCII_CR;
                state   <= CR;
              end else begin
                tx_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              cnt     <= cnt + CW'(1);
              shreg   <= shreg_next;
              tx_data <= ascii;
            end
          end
        end
        CR: begin
          if (xfer) begin
            tx_data <= ASCII_LF;
            state   <= LF;
          end
        end
        LF: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_string_sender.sv
// Directed bench for hex_string_sender: CRLF and digits-only builds side by side.
// Drives and samples on the falling edge, away from the active rising edge.
// Expected bytes are hand-written tables per scenario.
module tb_hex_string_sender;

  logic        clk;
  logic        reset_n;

  // Instance with CR LF appended
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Digits-only instance
  logic        start2;
  logic [31:0] value2;
  logic        busy2;
  logic        done2;
  logic [7:0]  tx_data2;
  logic        tx_valid2;
  logic        tx_ready2;

  int n_checks;
  int n_pass;

  logic [7:0] exp_b [0:9];
  int         exp_n;
  logic [7:0] exp_nc [0:7];

  hex_string_sender #(.NDIGITS(8), .SEND_CRLF(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  hex_string_sender #(.NDIGITS(8), .SEND_CRLF(1'b0)) dut_nc (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start2),
    .value    (value2),
    .busy     (busy2),
    .done     (done2),
    .tx_data  (tx_data2),
    .tx_valid (tx_valid2),
    .tx_ready (tx_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one string on the CRLF instance against exp_b/exp_n.
  // stall: cycles tx_ready is low before each byte is accepted.
  // poke: pulse start with another value while byte 3 transfers.
  // chain: issue a new start in the done cycle and check its first byte.
  task automatic send_and_check(input string name, input logic [31:0] v, input bit do_start,
                                input int stall, input bit poke, input bit chain,
                                input logic [31:0] chain_v, input logic [7:0] chain_first);
    if (do_start) begin
      start = 1'b1;
      value = v;
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy_on_start"}, busy, 1);
    end
    for (int i = 0; i < exp_n; i++) begin
      for (int s = 0; s < stall; s++) begin
        tx_ready = 1'b0;
        check($sformatf("%s_hold_valid_%0d_%0d", name, i, s), tx_valid, 1);
        check($sformatf("%s_hold_data_%0d_%0d", name, i, s), tx_data, exp_b[i]);
        @(negedge clk);
      end
      tx_ready = 1'b1;
      check($sformatf("%s_valid_%0d", name, i), tx_valid, 1);
      check($sformatf("%s_data_%0d", name, i), tx_data, exp_b[i]);
      if (poke && i == 3) begin
        start = 1'b1;
        value = 32'h12345678;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check({name, "_done"}, done, 1);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_valid_after"}, tx_valid, 0);
    if (chain) begin
      start = 1'b1;
      value = chain_v;
      @(negedge clk);
      start = 1'b0;
      check({name, "_done_pulse"}, done, 0);
      check({name, "_chain_valid"}, tx_valid, 1);
      check({name, "_chain_data"}, tx_data, chain_first);
    end else begin
      @(negedge clk);
      check({name, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    value     = '0;
    tx_ready  = 1'b0;
    start2    = 1'b0;
    value2    = '0;
    tx_ready2 = 1'b0;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_valid", tx_valid, 0);

    // DEADBEEF with tx_ready held high
    exp_b = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    exp_n = 10;
    tx_ready = 1'b1;
    send_and_check("fast", 32'hDEADBEEF, 1'b1, 0, 1'b0, 1'b0, 32'h0, 8'h00);

    // Same value with 3 stall cycles per byte
    send_and_check("stall", 32'hDEADBEEF, 1'b1, 3, 1'b0, 1'b0, 32'h0, 8'h00);

    // start re-pulsed with another value mid-string
    send_and_check("poke", 32'hDEADBEEF, 1'b1, 0, 1'b1, 1'b0, 32'h0, 8'h00);

    // Abort by reset after the third transfer
    tx_ready = 1'b1;
    start    = 1'b1;
    value    = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pre_data", tx_data, 8'h44);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", tx_data, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_no_resume_valid", tx_valid, 0);
    check("abort_no_resume_busy", busy, 0);
    exp_b = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h0D, 8'h0A};
    send_and_check("after_rst", 32'h0000000A, 1'b1, 0, 1'b0, 1'b0, 32'h0, 8'h00);

    // Back-to-back strings: start in the done cycle
    exp_b = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    send_and_check("chain1", 32'hDEADBEEF, 1'b1, 0, 1'b0, 1'b1, 32'h0000000A, 8'h30);
    exp_b = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h0D, 8'h0A};
    send_and_check("chain2", 32'h0000000A, 1'b0, 0, 1'b0, 1'b0, 32'h0, 8'h00);

    // Digits-only build: F0F0F0F0
    exp_nc    = '{8'h46, 8'h30, 8'h46, 8'h30, 8'h46, 8'h30, 8'h46, 8'h30};
    tx_ready2 = 1'b1;
    start2    = 1'b1;
    value2    = 32'hF0F0F0F0;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("nocrlf_valid_%0d", i), tx_valid2, 1);
      check($sformatf("nocrlf_data_%0d", i), tx_data2, exp_nc[i]);
      @(negedge clk);
    end
    check("nocrlf_done", done2, 1);
    check("nocrlf_busy_after", busy2, 0);
    check("nocrlf_valid_after", tx_valid2, 0);
    @(negedge clk);
    check("nocrlf_done_pulse", done2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
